// File: rtl/lane_gate_pkg.sv
// rtl/lane_gate_pkg.sv - shared types and default timing for the barrier lane arbiter
package lane_gate_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        OPENING   = 3'd1,
        WAIT_PASS = 3'd2,
        CLOSING   = 3'd3,
        EVAC      = 3'd4
    } lane_state_t;

    localparam logic DIR_ENT = 1'b0;
    localparam logic DIR_SAI = 1'b1;

    localparam int DEF_CAPACITY     = 8;
    localparam int DEF_OPEN_CYCLES  = 4;
    localparam int DEF_CLOSE_CYCLES = 4;
    localparam int DEF_PASS_TIMEOUT = 64;
    localparam int DEF_TMR_W        = 8;

endpackage

// File: rtl/lane_req_arb.sv
// rtl/lane_req_arb.sv - entry/exit eligibility and tie-break for the shared lane
module lane_req_arb
    import lane_gate_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic req_ent,
    input  logic req_sai,
    input  logic full,
    input  logic occ_nz,
    input  logic last_grant,
    output logic win_dir,
    output logic win_valid
);

    logic ent_ok;
    logic sai_ok;

    always_comb begin
        ent_ok    = req_ent && !full;
        sai_ok    = req_sai && occ_nz;
        win_valid = ent_ok || sai_ok;
        win_dir   = DIR_SAI;
        if (ent_ok && sai_ok) begin
            // Round-robin favours the direction not served last; fixed mode favours exit.
            win_dir = RR_EN ? ~last_grant : DIR_SAI;
        end else if (ent_ok) begin
            win_dir = DIR_ENT;
        end
    end

endmodule

// File: rtl/lane_gate_arbiter.sv
// rtl/lane_gate_arbiter.sv - shared entry/exit barrier sequencer; RR_ARB_EN enables round-robin tie-break
module lane_gate_arbiter
    import lane_gate_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES,
    parameter int PASS_TIMEOUT = DEF_PASS_TIMEOUT,
    parameter int TMR_W        = DEF_TMR_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_ent,
    input  logic       req_sai,
    input  logic       pass_done,
    input  logic [7:0] occupancy,
    input  logic       emergencia,
    output logic       gate_open,
    output logic       lane_dir,
    output logic       grant_ent,
    output logic       grant_sai,
    output logic       increment,
    output logic       decrement,
    output logic       full,
    output logic       busy
);

    localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] PASS_LAST  = TMR_W'(PASS_TIMEOUT - 1);

    lane_state_t      state;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             win_dir;
    logic             win_valid;
    logic             last_grant;
    logic             occ_nz;

    assign full      = ({24'd0, occupancy} >= 32'(CAPACITY));
    assign busy      = (state != IDLE);
    assign occ_nz    = |occupancy;
    assign timer_nxt = (timer == '1) ? timer : timer + 1'b1;

`ifdef RR_ARB_EN
    localparam bit RR_EN = 1'b1;
    logic served;

    assign served = (state == WAIT_PASS) && (pass_done || (timer >= PASS_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= DIR_SAI;
        end else if (served) begin
            last_grant <= lane_dir;
        end
    end
`else
    localparam bit RR_EN = 1'b0;
    assign last_grant = DIR_SAI;
`endif

    lane_req_arb #(
        .RR_EN(RR_EN)
    ) u_arb (
        .req_ent   (req_ent),
        .req_sai   (req_sai),
        .full      (full),
        .occ_nz    (occ_nz),
        .last_grant(last_grant),
        .win_dir   (win_dir),
        .win_valid (win_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            gate_open <= 1'b0;
            lane_dir  <= DIR_ENT;
            grant_ent <= 1'b0;
            grant_sai <= 1'b0;
            increment <= 1'b0;
            decrement <= 1'b0;
        end else begin
            increment <= 1'b0;
            decrement <= 1'b0;
            timer     <= timer_nxt;
            if (emergencia) begin
                // A vehicle clearing in the same cycle as the alarm is still counted.
                if (state == WAIT_PASS && pass_done) begin
                    increment <= (lane_dir == DIR_ENT);
                    decrement <= (lane_dir == DIR_SAI);
                end else if (state == EVAC && pass_done && occ_nz) begin
                    decrement <= 1'b1;
                end
                state     <= EVAC;
                timer     <= '0;
                gate_open <= 1'b1;
                lane_dir  <= DIR_SAI;
                grant_ent <= 1'b0;
                grant_sai <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (win_valid) begin
                            state     <= OPENING;
                            timer     <= '0;
                            gate_open <= 1'b1;
                            lane_dir  <= win_dir;
                            grant_ent <= (win_dir == DIR_ENT);
                            grant_sai <= (win_dir == DIR_SAI);
                        end
                    end
                    OPENING: begin
                        if (timer >= OPEN_LAST) begin
                            state <= WAIT_PASS;
                            timer <= '0;
                        end
                    end
                    WAIT_PASS: begin
                        if (pass_done || (timer >= PASS_LAST)) begin
                            increment <= pass_done && (lane_dir == DIR_ENT);
                            decrement <= pass_done && (lane_dir == DIR_SAI);
                            state     <= CLOSING;
                            timer     <= '0;
                            gate_open <= 1'b0;
                            grant_ent <= 1'b0;
                            grant_sai <= 1'b0;
                        end
                    end
                    CLOSING: begin
                        if (timer >= CLOSE_LAST) begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    end
                    EVAC: begin
                        decrement <= pass_done && occ_nz;
                        state     <= CLOSING;
                        timer     <= '0;
                        gate_open <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        timer     <= '0;
                        gate_open <= 1'b0;
                        grant_ent <= 1'b0;
                        grant_sai <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lane_gate_arbiter.sv
// tb/tb_lane_gate_arbiter.sv - self-checking bench for lane_gate_arbiter
module tb_lane_gate_arbiter;

    localparam int CAP   = 8;
    localparam int OPEN  = 4;
    localparam int CLOSE = 4;
    localparam int TO    = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_ent, req_sai, pass_done, emergencia;
    logic [7:0] occupancy;
    logic       gate_open, lane_dir, grant_ent, grant_sai;
    logic       increment, decrement, full, busy;

    lane_gate_arbiter #(
        .CAPACITY(CAP), .OPEN_CYCLES(OPEN), .CLOSE_CYCLES(CLOSE),
        .PASS_TIMEOUT(TO), .TMR_W(8)
    ) dut (
        .clk(clk), .reset(reset), .req_ent(req_ent), .req_sai(req_sai),
        .pass_done(pass_done), .occupancy(occupancy), .emergencia(emergencia),
        .gate_open(gate_open), .lane_dir(lane_dir), .grant_ent(grant_ent),
        .grant_sai(grant_sai), .increment(increment), .decrement(decrement),
        .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_gate = 0, n_busy = 0, n_inc = 0, n_dec = 0;
    int s_gate, s_busy, s_inc, s_dec;
    logic prev_grant = 1'b0;
    logic grant_q[$];

    // Model: phase 0 idle, 1 serving (opening + waiting), 2 closing, 3 evacuation.
    // m_age counts cycles spent in the current phase.
    int   m_phase, m_age;
    logic m_dir, m_last, m_inc, m_dec;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_dir = 1'b0; m_last = 1'b1; m_inc = 1'b0; m_dec = 1'b0;
    endtask

    task automatic model_step();
        logic ent_ok, sai_ok;
        m_inc = 1'b0;
        m_dec = 1'b0;
        if (emergencia) begin
            if (m_phase == 1 && m_age >= OPEN && pass_done) begin
                m_inc = !m_dir; m_dec = m_dir; m_last = m_dir;
            end
            if (m_phase == 3 && pass_done && occupancy != 0) m_dec = 1'b1;
            m_phase = 3; m_age = 0; m_dir = 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    ent_ok = req_ent && (occupancy < CAP);
                    sai_ok = req_sai && (occupancy > 0);
                    if (ent_ok || sai_ok) begin
`ifdef RR_ARB_EN
                        m_dir = (ent_ok && sai_ok) ? !m_last : sai_ok;
`else
                        m_dir = sai_ok;
`endif
                        m_phase = 1; m_age = 0;
                    end
                end
                1: begin
                    if (m_age >= OPEN && (pass_done || m_age == OPEN + TO - 1)) begin
                        m_inc = pass_done && !m_dir;
                        m_dec = pass_done && m_dir;
                        m_last = m_dir;
                        m_phase = 2; m_age = 0;
                    end else m_age++;
                end
                2: begin
                    if (m_age == CLOSE - 1) begin m_phase = 0; m_age = 0; end
                    else m_age++;
                end
                default: begin
                    if (pass_done && occupancy != 0) m_dec = 1'b1;
                    m_phase = 2; m_age = 0;
                end
            endcase
        end
    endtask

    task automatic compare();
        chk("gate_open", gate_open, int'(m_phase == 1 || m_phase == 3));
        chk("grant_ent", grant_ent, int'(m_phase == 1 && !m_dir));
        chk("grant_sai", grant_sai, int'(m_phase == 1 && m_dir));
        chk("increment", increment, m_inc);
        chk("decrement", decrement, m_dec);
        chk("busy", busy, int'(m_phase != 0));
        chk("full", full, int'(occupancy >= CAP));
        if (m_phase != 0) chk("lane_dir", lane_dir, m_dir);
        n_gate += gate_open; n_busy += busy; n_inc += increment; n_dec += decrement;
        if ((grant_ent || grant_sai) && !prev_grant) grant_q.push_back(grant_sai);
        prev_grant = grant_ent || grant_sai;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            compare();
            @(posedge clk);
            if (reset) model_step();
            #1;
        end
    endtask

    task automatic snap();
        s_gate = n_gate; s_busy = n_busy; s_inc = n_inc; s_dec = n_dec;
    endtask

    task automatic pulse_pass();
        pass_done = 1'b1; tick(1); pass_done = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_ent = 0; req_sai = 0; pass_done = 0; emergencia = 0; occupancy = 8'd3;
        model_reset();
        tick(3);
        chk("rst_gate", gate_open, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        reset = 1'b1;
        tick(2);

        // Entry, pass on the 5th waiting cycle.
        snap(); req_ent = 1; tick(1); req_ent = 0; tick(8); pulse_pass(); tick(CLOSE + 2);
        chk("t1_gate_cycles", n_gate - s_gate, OPEN + 5);
        chk("t1_busy_cycles", n_busy - s_busy, OPEN + 5 + CLOSE);
        chk("t1_inc", n_inc - s_inc, 1);
        chk("t1_dec", n_dec - s_dec, 0);

        // Full lot refuses entry, exit still served.
        snap(); occupancy = 8'd8; req_ent = 1; tick(4);
        chk("t2_full", full, 1);
        chk("t2_no_grant", n_busy - s_busy, 0);
        req_sai = 1; tick(1); req_sai = 0; tick(OPEN + 2); pulse_pass(); tick(CLOSE + 2);
        chk("t2_gate_cycles", n_gate - s_gate, OPEN + 3);
        chk("t2_dec", n_dec - s_dec, 1);
        chk("t2_inc", n_inc - s_inc, 0);
        req_ent = 0;

        // Tie between both directions, two back-to-back services.
        snap(); grant_q.delete(); occupancy = 8'd4; req_ent = 1; req_sai = 1;
        tick(5); pulse_pass(); tick(5); req_ent = 0; req_sai = 0; tick(4); pulse_pass(); tick(CLOSE + 2);
        chk("t3_grants", grant_q.size(), 2);
        if (grant_q.size() == 2) begin
`ifdef RR_ARB_EN
            chk("t3_dir0", grant_q[0], 0);
            chk("t3_dir1", grant_q[1], 1);
            chk("t3_inc", n_inc - s_inc, 1);
            chk("t3_dec", n_dec - s_dec, 1);
`else
            chk("t3_dir0", grant_q[0], 1);
            chk("t3_dir1", grant_q[1], 1);
            chk("t3_inc", n_inc - s_inc, 0);
            chk("t3_dec", n_dec - s_dec, 2);
`endif
        end

        // Pass timeout, then pass on the final waiting cycle.
        snap(); occupancy = 8'd3; req_ent = 1; tick(1); req_ent = 0; tick(OPEN + TO + CLOSE + 3);
        chk("t4_to_gate", n_gate - s_gate, OPEN + TO);
        chk("t4_to_inc", n_inc - s_inc, 0);
        snap(); req_ent = 1; tick(1); req_ent = 0; tick(OPEN + TO - 1); pulse_pass(); tick(CLOSE + 2);
        chk("t4_last_gate", n_gate - s_gate, OPEN + TO);
        chk("t4_last_inc", n_inc - s_inc, 1);

        // Emergency during opening.
        snap(); occupancy = 8'd2; req_ent = 1; tick(1); req_ent = 0; tick(1);
        emergencia = 1; tick(1);
        chk("t5_gate", gate_open, 1);
        chk("t5_dir", lane_dir, 1);
        chk("t5_grant", grant_ent | grant_sai, 0);
        pulse_pass(); tick(1); occupancy = 8'd1;
        pulse_pass(); tick(1); occupancy = 8'd0;
        pulse_pass(); tick(1);
        chk("t5_dec", n_dec - s_dec, 2);
        chk("t5_inc", n_inc - s_inc, 0);
        emergencia = 0; tick(CLOSE + 2);
        chk("t5_idle", busy, 0);

        // Asynchronous reset in the middle of the waiting phase.
        snap(); occupancy = 8'd3; req_ent = 1; tick(1); req_ent = 0; tick(6);
        pass_done = 1; #2; reset = 1'b0; model_reset(); #1;
        chk("t6_gate", gate_open, 0);
        chk("t6_grant", grant_ent, 0);
        chk("t6_busy", busy, 0);
        tick(1); pass_done = 0; reset = 1'b1; s_inc = n_inc; tick(3);
        chk("t6_no_pulse", n_inc - s_inc, 0);
        chk("t6_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
